pipe_stage_reg: RTL and testbench

- Parametrised elastic pipeline stage register for the CPU datapath (ID/EXE, EXE/MEM, MEM/WB boundaries).
- Carries CHANNELS independent WIDTH-bit fields as one beat.
- Adds what a plain load-always stage register lacks: valid/ready handshake, working freeze (stall), flush (bubble insertion), and an optional skid entry so in_ready is registered and never combinationally depends on out_ready.

---
 rtl/pipe_stage_reg.sv | 145 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Elastic pipeline stage register (valid/ready) carrying CHANNELS
//            WIDTH-bit fields per beat, with freeze, flush and an optional
//            skid entry that makes in_ready a registered signal.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter bit SKID     = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      freeze,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [1:0]                occupancy
);

  localparam int BUS_W = CHANNELS * WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_nxt;
  logic [BUS_W-1:0]   main_q;
  logic [BUS_W-1:0]   skid_q;
  logic               xfer_en;
  logic               push;
  logic               pop;
  logic               load_main_in;
  logic               load_main_skid;
  logic               load_skid;

  // Transfers on both sides are only possible outside reset, freeze and flush.
  assign xfer_en   = rst && !freeze && !flush;
  assign out_valid = (state_q != EMPTY) && xfer_en;
  assign out_data  = main_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  generate
    if (SKID) begin : g_skid
      logic ready_q;

      // Registered acceptance: ready whenever the stage will not be full next cycle.
      always_ff @(posedge clk) begin
        if (!rst) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_nxt != TWO);
        end
      end

      assign in_ready = ready_q && xfer_en;
    end else begin : g_noskid
      // Single entry: accept when empty or when the held beat leaves this edge.
      assign in_ready = ((state_q == EMPTY) || out_ready) && xfer_en;
    end
  endgenerate

  // Next-state and data-path load selection; flush overrides the handshake.
  always_comb begin
    state_nxt      = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            load_main_in = 1'b1;
          end else if (push && SKID) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  // State register with the occupancy count kept in step with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= EMPTY;
      occupancy <= 2'd0;
    end else begin
      state_q <= state_nxt;
      case (state_nxt)
        ONE:     occupancy <= 2'd1;
        TWO:     occupancy <= 2'd2;
        default: occupancy <= 2'd0;
      endcase
    end
  end

  // Beat storage; flush clears only the state, so data registers keep stale contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Self-checking bench for pipe_stage_reg; drives a SKID=1 and a
//            SKID=0 instance with the same stimulus and compares both against
//            a FIFO-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int W  = 32;
  localparam int C  = 2;
  localparam int BW = W * C;

  logic          clk;
  logic          rst;
  logic          freeze;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [BW-1:0] in_data;

  logic          in_ready1, out_valid1;
  logic [BW-1:0] out_data1;
  logic [1:0]    occ1;
  logic          in_ready0, out_valid0;
  logic [BW-1:0] out_data0;
  logic [1:0]    occ0;

  int tests_run;
  int fails;

  // Reference model: each stage is a FIFO of beats with capacity 2 or 1.
  logic [BW-1:0] q1[$];
  logic [BW-1:0] q0[$];

  pipe_stage_reg #(.WIDTH(W), .CHANNELS(C), .SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1)
  );

  pipe_stage_reg #(.WIDTH(W), .CHANNELS(C), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occ0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Can the stage take a beat now: skid stage when not full, single stage when
  // empty or when its beat leaves this cycle.
  function automatic logic e_rdy(input bit sk);
    if (!rst || freeze || flush) return 1'b0;
    if (sk) return (q1.size() < 2);
    return (q0.size() == 0) || out_ready;
  endfunction

  function automatic logic e_val(input bit sk);
    if (!rst || freeze || flush) return 1'b0;
    return sk ? (q1.size() != 0) : (q0.size() != 0);
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic step();
    bit p1, u1, p0, u0;
    p1 = e_val(1'b1) && out_ready;
    u1 = e_rdy(1'b1) && in_valid;
    p0 = e_val(1'b0) && out_ready;
    u0 = e_rdy(1'b0) && in_valid;
    @(posedge clk);
    if (!rst || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (p1) void'(q1.pop_front());
      if (u1) q1.push_back(in_data);
      if (p0) void'(q0.pop_front());
      if (u0) q0.push_back(in_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; in_data = 64'hDEAD_BEEF_0BAD_F00D;
    step();
    step();
    #1;
    tests_run++;
    if (in_ready1 !== 1'b0 || out_valid1 !== 1'b0 || occ1 !== 2'd0 || out_data1 !== 64'd0) begin
      fails++;
      $display("FAIL reset_skid1: rdy=%b val=%b occ=%0d data=%h expected 0/0/0/0", in_ready1, out_valid1, occ1, out_data1);
    end
    tests_run++;
    if (in_ready0 !== 1'b0 || out_valid0 !== 1'b0 || occ0 !== 2'd0 || out_data0 !== 64'd0) begin
      fails++;
      $display("FAIL reset_skid0: rdy=%b val=%b occ=%0d data=%h expected 0/0/0/0", in_ready0, out_valid0, occ0, out_data0);
    end
    rst = 1'b1; in_valid = 1'b0;
    #1;
    tests_run++;
    if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b/%b expected 1/1", in_ready1, in_ready0);
    end
  endtask

  task automatic test_flow();
    logic [BW-1:0] a;
    a = {32'h0000_0022, 32'h0000_0011};
    in_valid = 1'b1; out_ready = 1'b1; in_data = a;
    step();
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid1 !== 1'b1 || out_data1 !== a || occ1 !== 2'd1) begin
      fails++;
      $display("FAIL flow_first: val=%b data=%h occ=%0d expected 1/%h/1", out_valid1, out_data1, occ1, a);
    end
    step();
    #1;
    tests_run++;
    if (out_valid1 !== 1'b0 || occ1 !== 2'd0 || occ0 !== 2'd0) begin
      fails++;
      $display("FAIL flow_drain: val=%b occ1=%0d occ0=%0d expected 0/0/0", out_valid1, occ1, occ0);
    end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] b1, b2;
    b1 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
    out_ready = 1'b0; in_valid = 1'b1; in_data = b1;
    step();
    in_data = b2;
    step();
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (occ1 !== 2'd2 || in_ready1 !== 1'b0) begin
      fails++;
      $display("FAIL bp_full: occ=%0d rdy=%b expected 2/0", occ1, in_ready1);
    end
    tests_run++;
    if (occ0 !== 2'd1 || out_data0 !== b1) begin
      fails++;
      $display("FAIL bp_single: occ=%0d data=%h expected 1/%h", occ0, out_data0, b1);
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (out_valid1 !== 1'b1 || out_data1 !== b1) begin
      fails++;
      $display("FAIL bp_first_out: val=%b data=%h expected 1/%h", out_valid1, out_data1, b1);
    end
    step();
    #1;
    tests_run++;
    if (out_valid1 !== 1'b1 || out_data1 !== b2 || occ1 !== 2'd1) begin
      fails++;
      $display("FAIL bp_second_out: val=%b data=%h occ=%0d expected 1/%h/1", out_valid1, out_data1, occ1, b2);
    end
    step();
    #1;
    tests_run++;
    if (out_valid1 !== 1'b0 || occ1 !== 2'd0 || out_valid0 !== 1'b0) begin
      fails++;
      $display("FAIL bp_empty: val1=%b occ1=%0d val0=%b expected 0/0/0", out_valid1, occ1, out_valid0);
    end
  endtask

  task automatic test_freeze();
    logic [BW-1:0] c, d;
    c = {$urandom, $urandom};
    d = ~c;
    out_ready = 1'b0; in_valid = 1'b1; in_data = c;
    step();
    freeze = 1'b1; out_ready = 1'b1; in_data = d;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (in_ready1 !== 1'b0 || out_valid1 !== 1'b0 || occ1 !== 2'd1 || out_data1 !== c) begin
        fails++;
        $display("FAIL freeze_hold[%0d]: rdy=%b val=%b occ=%0d data=%h expected 0/0/1/%h", i, in_ready1, out_valid1, occ1, out_data1, c);
      end
      step();
    end
    freeze = 1'b0; in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid1 !== 1'b1 || out_data1 !== c || out_valid0 !== 1'b1 || out_data0 !== c) begin
      fails++;
      $display("FAIL freeze_release: val=%b/%b data=%h/%h expected 1/1 %h", out_valid1, out_valid0, out_data1, out_data0, c);
    end
    step();
    #1;
    tests_run++;
    if (occ1 !== 2'd0 || occ0 !== 2'd0) begin
      fails++;
      $display("FAIL freeze_drain: occ=%0d/%0d expected 0/0", occ1, occ0);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = {$urandom, $urandom};
    step();
    in_data = {$urandom, $urandom};
    step();
    flush = 1'b1; freeze = 1'b1; in_data = 64'h0123_4567_89AB_CDEF;
    #1;
    tests_run++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b0) begin
      fails++;
      $display("FAIL flush_mask: val=%b rdy=%b expected 0/0", out_valid1, in_ready1);
    end
    step();
    flush = 1'b0; freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    tests_run++;
    if (occ1 !== 2'd0 || out_valid1 !== 1'b0 || occ0 !== 2'd0 || out_valid0 !== 1'b0) begin
      fails++;
      $display("FAIL flush_empty: occ=%0d/%0d val=%b/%b expected 0/0 0/0", occ1, occ0, out_valid1, out_valid0);
    end
    step();
    #1;
    tests_run++;
    if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
      fails++;
      $display("FAIL flush_no_capture: val=%b/%b expected 0/0", out_valid1, out_valid0);
    end
  endtask

  task automatic test_throughput();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = {32'(i), 32'(i)};
      #1;
      tests_run++;
      if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
        fails++;
        $display("FAIL tput_ready[%0d]: got %b/%b expected 1/1", i, in_ready0, in_ready1);
      end
      if (i > 0) begin
        tests_run++;
        if (out_valid0 !== 1'b1 || out_data0 !== {32'(i - 1), 32'(i - 1)} || out_data1 !== {32'(i - 1), 32'(i - 1)}) begin
          fails++;
          $display("FAIL tput_data[%0d]: val=%b data=%h/%h expected 1/%0d", i, out_valid0, out_data0, out_data1, i - 1);
        end
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid0 !== 1'b1 || out_data0 !== {32'd15, 32'd15}) begin
      fails++;
      $display("FAIL tput_last: val=%b data=%h expected 1/15", out_valid0, out_data0);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] f, g, h;
    f = {$urandom, $urandom} | 64'h1;
    g = {$urandom, $urandom} | 64'h1;
    h = 64'h0000_0055_0000_0066;
    out_ready = 1'b0; in_valid = 1'b1; in_data = f;
    step();
    in_data = g;
    step();
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (occ1 !== 2'd2) begin
      fails++;
      $display("FAIL rmid_full: occ=%0d expected 2", occ1);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    tests_run++;
    if (occ1 !== 2'd0 || out_valid1 !== 1'b0 || out_data1 !== 64'd0 || occ0 !== 2'd0 || out_data0 !== 64'd0) begin
      fails++;
      $display("FAIL rmid_clear: occ=%0d val=%b data=%h/%h expected 0/0/0/0", occ1, out_valid1, out_data1, out_data0);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = h;
    step();
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid1 !== 1'b1 || out_data1 !== h) begin
      fails++;
      $display("FAIL rmid_next: val=%b data=%h expected 1/%h", out_valid1, out_data1, h);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst       = ($urandom_range(0, 63) != 0);
      freeze    = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = $urandom_range(0, 1) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_data   = {$urandom, $urandom};
      #1;
      tests_run++;
      if (in_ready1 !== e_rdy(1'b1) || out_valid1 !== e_val(1'b1) || occ1 !== 2'(q1.size())
          || (e_val(1'b1) && out_data1 !== q1[0])) begin
        fails++;
        $display("FAIL rand_skid1[%0d]: rdy=%b val=%b occ=%0d data=%h expected %b/%b/%0d", i,
                 in_ready1, out_valid1, occ1, out_data1, e_rdy(1'b1), e_val(1'b1), q1.size());
      end
      tests_run++;
      if (in_ready0 !== e_rdy(1'b0) || out_valid0 !== e_val(1'b0) || occ0 !== 2'(q0.size())
          || (e_val(1'b0) && out_data0 !== q0[0])) begin
        fails++;
        $display("FAIL rand_skid0[%0d]: rdy=%b val=%b occ=%0d data=%h expected %b/%b/%0d", i,
                 in_ready0, out_valid0, occ0, out_data0, e_rdy(1'b0), e_val(1'b0), q0.size());
      end
      step();
    end
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    test_reset();
    test_flow();
    test_backpressure();
    test_freeze();
    test_flush();
    test_throughput();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
